// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: PLL reset sequencing, lock qualification, lock-loss supervision
// and runtime reconfiguration of the PLL dynamic divider/duty/phase ports.
module pll_dyn_cfg_ctrl #(
   parameter int          RST_CYCLES   = 16,
   parameter int          LOCK_STABLE  = 64,
   parameter int          LOCK_TIMEOUT = 65536,
   parameter int          MAX_RETRY    = 2,
   parameter logic [9:0]  DEF_IDIV     = 10'd2,
   parameter logic [9:0]  DEF_FDIV     = 10'd32,
   parameter logic [9:0]  DEF_ODIV0    = 10'd100,
   parameter logic [9:0]  DEF_DUTY0    = 10'd100,
   parameter logic [12:0] DEF_PHASE0   = 13'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [9:0]  cfg_idiv,
   input  logic [9:0]  cfg_fdiv,
   input  logic [9:0]  cfg_odiv0,
   input  logic [9:0]  cfg_duty0,
   input  logic [12:0] cfg_phase0,
   input  logic        pll_lock,
   output logic        pll_rst,
   output logic        rstodiv,
   output logic [9:0]  dyn_idiv,
   output logic [9:0]  dyn_fdiv,
   output logic [9:0]  dyn_odiv0,
   output logic [9:0]  dyn_duty0,
   output logic [12:0] dyn_phase0,
   output logic        locked,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic [7:0]  lock_loss_cnt
);
   typedef enum logic [1:0] {RST_PLL, WAIT_LOCK, IDLE} state_t;
   state_t      state, state_d;
   logic        lock_m, lock_s;
   logic [19:0] cnt, cnt_d;
   logic [19:0] stab, stab_d;
   logic [7:0]  retry, retry_d;
   logic [9:0]  idiv_d, fdiv_d, odiv_d, duty_d;
   logic [12:0] phase_d;
   logic        locked_d, done_d, err_d;
   logic [7:0]  loss_d;
   logic        req_ok, loss;
   always_ff @(posedge clk) begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
   end
   // duty must lie in [1, 2*odiv0-1]; widened so 2*odiv0 cannot wrap
   assign req_ok    = (|cfg_idiv) && (|cfg_fdiv) && (|cfg_odiv0) && (|cfg_duty0) &&
                      ({1'b0, cfg_duty0} < {cfg_odiv0, 1'b0});
   assign loss      = locked && !lock_s;
   assign cfg_ready = (state == IDLE) && !loss;
   assign pll_rst   = (state == RST_PLL);
   assign rstodiv   = !locked;
   always_comb begin
      state_d  = state;
      cnt_d    = cnt + 20'd1;
      stab_d   = 20'd0;
      retry_d  = retry;
      idiv_d   = dyn_idiv;
      fdiv_d   = dyn_fdiv;
      odiv_d   = dyn_odiv0;
      duty_d   = dyn_duty0;
      phase_d  = dyn_phase0;
      locked_d = locked;
      done_d   = 1'b0;
      err_d    = 1'b0;
      loss_d   = lock_loss_cnt;
      case (state)
         RST_PLL: begin
            locked_d = 1'b0;
            if (cnt == 20'(RST_CYCLES - 1)) begin
               state_d = WAIT_LOCK;
               cnt_d   = 20'd0;
            end
         end
         WAIT_LOCK: begin
            stab_d = lock_s ? stab + 20'd1 : 20'd0;
            if (lock_s && stab == 20'(LOCK_STABLE - 1)) begin
               state_d  = IDLE;
               cnt_d    = 20'd0;
               locked_d = 1'b1;
               done_d   = 1'b1;
               retry_d  = 8'd0;
            end else if (cnt == 20'(LOCK_TIMEOUT - 1)) begin
               cnt_d = 20'd0;
               if (retry < 8'(MAX_RETRY)) begin
                  retry_d = retry + 8'd1;
                  state_d = RST_PLL;
               end else begin
                  retry_d = 8'd0;
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         IDLE: begin
            cnt_d = 20'd0;
            // lock loss wins over a request arriving in the same cycle
            if (loss) begin
               locked_d = 1'b0;
               loss_d   = lock_loss_cnt + {7'd0, lock_loss_cnt != 8'hff};
               state_d  = RST_PLL;
            end else if (cfg_valid) begin
               if (req_ok) begin
                  idiv_d   = cfg_idiv;
                  fdiv_d   = cfg_fdiv;
                  odiv_d   = cfg_odiv0;
                  duty_d   = cfg_duty0;
                  phase_d  = cfg_phase0;
                  retry_d  = 8'd0;
                  locked_d = 1'b0;
                  state_d  = RST_PLL;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = RST_PLL;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RST_PLL;
         cnt           <= 20'd0;
         stab          <= 20'd0;
         retry         <= 8'd0;
         dyn_idiv      <= DEF_IDIV;
         dyn_fdiv      <= DEF_FDIV;
         dyn_odiv0     <= DEF_ODIV0;
         dyn_duty0     <= DEF_DUTY0;
         dyn_phase0    <= DEF_PHASE0;
         locked        <= 1'b0;
         cfg_done      <= 1'b0;
         cfg_err       <= 1'b0;
         lock_loss_cnt <= 8'd0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         stab          <= stab_d;
         retry         <= retry_d;
         dyn_idiv      <= idiv_d;
         dyn_fdiv      <= fdiv_d;
         dyn_odiv0     <= odiv_d;
         dyn_duty0     <= duty_d;
         dyn_phase0    <= phase_d;
         locked        <= locked_d;
         cfg_done      <= done_d;
         cfg_err       <= err_d;
         lock_loss_cnt <= loss_d;
      end
   end
endmodule
